outport_arbiter: RTL and testbench

OUTPORT_ARBITER -- requirements
Module: outport_arbiter

---
 rtl/outport_arbiter.sv | 128 ++++++++++++
 tb/tb_outport_arbiter.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/outport_arbiter.sv
// Output-port arbiter: round-robin over packet heads, then locked to one owner until its tail
// transfers. Define RAVENOC_ARB_PKT_CNT_EN to add the 16-bit tail-transfer counter pkt_cnt_o.
module outport_arbiter #(
  parameter int unsigned N_REQ  = 4,
  parameter int unsigned FLIT_W = 34
) (
  input  logic                      clk_noc,
  input  logic                      arst_noc,
  input  logic [N_REQ-1:0]          req_valid_i,
  input  logic [N_REQ-1:0]          req_head_i,
  input  logic [N_REQ-1:0]          req_tail_i,
  input  logic [N_REQ*FLIT_W-1:0]   req_flit_i,
  output logic [N_REQ-1:0]          req_ready_o,
  output logic                      out_valid_o,
  output logic [FLIT_W-1:0]         out_flit_o,
  output logic                      out_tail_o,
  input  logic                      out_ready_i,
  output logic [N_REQ-1:0]          grant_o,
  output logic                      busy_o
`ifdef RAVENOC_ARB_PKT_CNT_EN
  ,
  output logic [15:0]               pkt_cnt_o
`endif
);

  localparam int unsigned IdxW = $clog2(N_REQ);

  typedef enum logic [0:0] {StIdle, StLocked} state_e;

  state_e          state_q, state_d;
  logic [IdxW-1:0] owner_q, owner_d;
  logic [IdxW-1:0] ptr_q, ptr_d;

  logic [N_REQ-1:0]  cand;
  logic              found;
  logic [IdxW-1:0]   pick;
  logic [IdxW-1:0]   idx;
  logic              locked;
  logic              xfer_tail;
  logic [FLIT_W-1:0] own_flit;

  // Body flits without a head are never arbitration candidates.
  assign cand = req_valid_i & req_head_i;

  // Search starts just after the last owner so every requester gets a turn.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = '0;
    for (int unsigned i = 1; i <= N_REQ; i++) begin
      idx = IdxW'((32'(ptr_q) + i) % N_REQ);
      if (!found && cand[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  assign locked   = (state_q == StLocked);
  assign own_flit = req_flit_i[owner_q*FLIT_W +: FLIT_W];

  always_comb begin
    req_ready_o = '0;
    out_valid_o = 1'b0;
    out_flit_o  = '0;
    out_tail_o  = 1'b0;
    grant_o     = '0;
    if (locked) begin
      out_valid_o          = req_valid_i[owner_q];
      out_flit_o           = own_flit;
      out_tail_o           = req_tail_i[owner_q];
      req_ready_o[owner_q] = out_ready_i;
      grant_o[owner_q]     = 1'b1;
    end
  end

  assign busy_o    = locked;
  assign xfer_tail = out_valid_o & out_ready_i & out_tail_o;

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      StIdle: begin
        if (found) begin
          state_d = StLocked;
          owner_d = pick;
        end
      end
      StLocked: begin
        if (xfer_tail) begin
          state_d = StIdle;
          ptr_d   = owner_q;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Reset pointer at N_REQ-1 makes requester 0 the first winner.
  always_ff @(posedge clk_noc or negedge arst_noc) begin
    if (!arst_noc) begin
      state_q <= StIdle;
      owner_q <= '0;
      ptr_q   <= IdxW'(N_REQ - 1);
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
    end
  end

`ifdef RAVENOC_ARB_PKT_CNT_EN
  logic [15:0] pkt_cnt_q;

  always_ff @(posedge clk_noc or negedge arst_noc) begin
    if (!arst_noc) begin
      pkt_cnt_q <= '0;
    end else if (xfer_tail) begin
      pkt_cnt_q <= pkt_cnt_q + 16'd1;
    end
  end

  assign pkt_cnt_o = pkt_cnt_q;
`endif

endmodule

// File: tb/tb_outport_arbiter.sv
// Bench for outport_arbiter: directed vector table, hand-written packet sequences and a
// randomized run against a queue-free behavioural model of the arbitration rules.
module tb_outport_arbiter;

  localparam int N = 4;
  localparam int W = 34;

  logic           clk_noc = 1'b0;
  logic           arst_noc;
  logic [N-1:0]   req_valid_i, req_head_i, req_tail_i;
  logic [N*W-1:0] req_flit_i;
  logic [N-1:0]   req_ready_o;
  logic           out_valid_o, out_tail_o, out_ready_i, busy_o;
  logic [W-1:0]   out_flit_o;
  logic [N-1:0]   grant_o;
`ifdef RAVENOC_ARB_PKT_CNT_EN
  logic [15:0]    pkt_cnt_o;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk_noc = ~clk_noc;

  outport_arbiter #(
    .N_REQ (N),
    .FLIT_W(W)
  ) dut (
    .clk_noc    (clk_noc),
    .arst_noc   (arst_noc),
    .req_valid_i(req_valid_i),
    .req_head_i (req_head_i),
    .req_tail_i (req_tail_i),
    .req_flit_i (req_flit_i),
    .req_ready_o(req_ready_o),
    .out_valid_o(out_valid_o),
    .out_flit_o (out_flit_o),
    .out_tail_o (out_tail_o),
    .out_ready_i(out_ready_i),
    .grant_o    (grant_o),
    .busy_o     (busy_o)
`ifdef RAVENOC_ARB_PKT_CNT_EN
    ,
    .pkt_cnt_o  (pkt_cnt_o)
`endif
  );

  typedef struct {
    logic [N-1:0] valid;
    logic [N-1:0] head;
    logic [N-1:0] tail;
    logic         ready;
    logic [N-1:0] exp_grant;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] flit_of(input int i);
    return req_flit_i[i*W +: W];
  endfunction

  task automatic set_flit(input int i, input logic [W-1:0] v);
    req_flit_i[i*W +: W] = v;
  endtask

  task automatic drive(input logic [N-1:0] v, input logic [N-1:0] h, input logic [N-1:0] t,
                       input logic r);
    req_valid_i = v;
    req_head_i  = h;
    req_tail_i  = t;
    out_ready_i = r;
  endtask

  // All outputs follow from the expected owner (one-hot g, zero when idle) and current inputs.
  task automatic expect_grant(input string name, input logic [N-1:0] g);
    logic [W-1:0] ef;
    ef = '0;
    for (int i = 0; i < N; i++) if (g[i]) ef = flit_of(i);
    chk({name, ".grant"}, 64'(grant_o), 64'(g));
    chk({name, ".busy"}, 64'(busy_o), 64'(g != '0));
    chk({name, ".valid"}, 64'(out_valid_o), 64'((g & req_valid_i) != '0));
    chk({name, ".tail"}, 64'(out_tail_o), 64'((g & req_tail_i) != '0));
    chk({name, ".ready"}, 64'(req_ready_o), 64'(out_ready_i ? g : '0));
    chk({name, ".flit"}, 64'(out_flit_o), 64'(ef));
  endtask

  task automatic step(input string name, input logic [N-1:0] v, input logic [N-1:0] h,
                      input logic [N-1:0] t, input logic r, input logic [N-1:0] g);
    @(negedge clk_noc);
    drive(v, h, t, r);
    #1;
    expect_grant(name, g);
  endtask

  task automatic do_reset();
    @(negedge clk_noc);
    drive('0, '0, '0, 1'b0);
    arst_noc = 1'b0;
    #1;
    expect_grant("reset", '0);
    @(negedge clk_noc);
    arst_noc = 1'b1;
  endtask

  // Behavioural model state: owner index, locked flag, last-served pointer, tail count.
  bit m_locked;
  int m_owner;
  int m_ptr;
  int m_cnt;

  vec_t tbl[13];

  initial begin
    logic [W-1:0] held;
    logic [N-1:0] eg;
    bit           hit;
    int           idx;

    arst_noc    = 1'b0;
    req_flit_i  = '0;
    drive('0, '0, '0, 1'b0);
    #1;
    expect_grant("por", '0);
    do_reset();

    // All four requesters sending single-flit packets: 0,1,2,3,0 with an idle cycle between.
    for (int i = 0; i < N; i++) set_flit(i, W'(34'h2_0000_0000) | W'(i + 16'hA0));
    tbl[0]  = '{4'hF, 4'hF, 4'hF, 1'b1, 4'b0000};
    tbl[1]  = '{4'hF, 4'hF, 4'hF, 1'b1, 4'b0001};
    tbl[2]  = '{4'hF, 4'hF, 4'hF, 1'b1, 4'b0000};
    tbl[3]  = '{4'hF, 4'hF, 4'hF, 1'b1, 4'b0010};
    tbl[4]  = '{4'hF, 4'hF, 4'hF, 1'b1, 4'b0000};
    tbl[5]  = '{4'hF, 4'hF, 4'hF, 1'b1, 4'b0100};
    tbl[6]  = '{4'hF, 4'hF, 4'hF, 1'b1, 4'b0000};
    tbl[7]  = '{4'hF, 4'hF, 4'hF, 1'b1, 4'b1000};
    tbl[8]  = '{4'hF, 4'hF, 4'hF, 1'b1, 4'b0000};
    tbl[9]  = '{4'hF, 4'hF, 4'hF, 1'b1, 4'b0001};
    // Valid body flit without head from requester 1 is never granted.
    tbl[10] = '{4'b0010, 4'b0000, 4'b0000, 1'b1, 4'b0000};
    tbl[11] = '{4'b0010, 4'b0000, 4'b0010, 1'b1, 4'b0000};
    tbl[12] = '{4'b0010, 4'b0000, 4'b0000, 1'b1, 4'b0000};
    foreach (tbl[k]) begin
      step($sformatf("tbl%0d", k), tbl[k].valid, tbl[k].head, tbl[k].tail, tbl[k].ready,
           tbl[k].exp_grant);
    end

    // Three-flit packet from 2 is not preempted by a head from 0.
    do_reset();
    set_flit(2, 34'h1_1111_0001);
    step("p3.arb", 4'b0100, 4'b0100, 4'b0000, 1'b1, 4'b0000);
    chk("p3.head_flit", 64'(out_flit_o), 64'(0));
    step("p3.head", 4'b0100, 4'b0100, 4'b0000, 1'b1, 4'b0100);
    set_flit(2, 34'h1_1111_0002);
    set_flit(0, 34'h0_0000_0BAD);
    step("p3.body", 4'b0101, 4'b0001, 4'b0001, 1'b1, 4'b0100);
    set_flit(2, 34'h1_1111_0003);
    step("p3.tail", 4'b0101, 4'b0001, 4'b0101, 1'b1, 4'b0100);
    step("p3.bubble", 4'b0001, 4'b0001, 4'b0001, 1'b1, 4'b0000);
    step("p3.next", 4'b0001, 4'b0001, 4'b0001, 1'b1, 4'b0001);

    // Downstream stall for five cycles, then owner valid drop, then tail.
    do_reset();
    set_flit(1, 34'h3_CAFE_0001);
    step("st.arb", 4'b0010, 4'b0010, 4'b0000, 1'b1, 4'b0000);
    held = 34'h3_CAFE_0001;
    for (int k = 0; k < 5; k++) begin
      step($sformatf("st.stall%0d", k), 4'b0010, 4'b0010, 4'b0000, 1'b0, 4'b0010);
      chk("st.flit_stable", 64'(out_flit_o), 64'(held));
    end
    step("st.go", 4'b0010, 4'b0010, 4'b0000, 1'b1, 4'b0010);
    step("st.drop", 4'b0001, 4'b0001, 4'b0001, 1'b1, 4'b0010);
    chk("st.drop_valid", 64'(out_valid_o), 64'(0));
    set_flit(1, 34'h3_CAFE_0002);
    step("st.tail", 4'b0011, 4'b0001, 4'b0011, 1'b1, 4'b0010);
    step("st.bubble", 4'b0001, 4'b0001, 4'b0001, 1'b1, 4'b0000);
    step("st.next", 4'b0001, 4'b0001, 4'b0001, 1'b1, 4'b0001);

    // Reset in the middle of a packet from requester 3.
    do_reset();
    step("rm.arb", 4'b1000, 4'b1000, 4'b0000, 1'b1, 4'b0000);
    step("rm.head", 4'b1000, 4'b1000, 4'b0000, 1'b1, 4'b1000);
    @(negedge clk_noc);
    drive(4'hF, 4'hF, 4'h0, 1'b1);
    arst_noc = 1'b0;
    #1;
    expect_grant("rm.inreset", '0);
    @(negedge clk_noc);
    #1;
    expect_grant("rm.held", '0);
    arst_noc = 1'b1;
    #1;
    expect_grant("rm.release", '0);
    @(negedge clk_noc);
    #1;
    expect_grant("rm.first", 4'b0001);

    // Randomized traffic against the model.
    do_reset();
    m_locked = 1'b0;
    m_owner  = 0;
    m_ptr    = N - 1;
    m_cnt    = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk_noc);
      for (int i = 0; i < N; i++) begin
        req_valid_i[i] = ($urandom_range(99) < 70);
        req_head_i[i]  = ($urandom_range(99) < 35);
        req_tail_i[i]  = ($urandom_range(99) < 40);
        set_flit(i, W'({$urandom, $urandom}));
      end
      out_ready_i = ($urandom_range(99) < 75);
      #1;
      eg = m_locked ? N'(1 << m_owner) : '0;
      expect_grant("rand", eg);
      if (m_locked) begin
        if (req_valid_i[m_owner] && out_ready_i && req_tail_i[m_owner]) begin
          m_locked = 1'b0;
          m_ptr    = m_owner;
          m_cnt++;
        end
      end else begin
        hit = 1'b0;
        for (int k = 1; k <= N; k++) begin
          idx = (m_ptr + k) % N;
          if (!hit && req_valid_i[idx] && req_head_i[idx]) begin
            hit      = 1'b1;
            m_locked = 1'b1;
            m_owner  = idx;
          end
        end
      end
    end
`ifdef RAVENOC_ARB_PKT_CNT_EN
    @(negedge clk_noc);
    drive('0, '0, '0, 1'b0);
    #1;
    chk("pkt_cnt", 64'(pkt_cnt_o), 64'(m_cnt[15:0]));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
